sync_debounce_edge: RTL

Downstream consumer of the two-flop synchronizer. Takes the already-synchronized level on `sig_in` and rejects pulses shorter than `STABLE` cycles, so that only stable transitions pass. For each accepted transition it emits a one-cycle `rise` or `fall` strobe and increments a wrapping event counter. Everything runs in the single `clk` domain.

---
 rtl/sync_debounce_edge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sync_debounce_edge.sv
// ---------------------------------------------------------------------------
// sync_debounce_edge
//
// Debounces an already-synchronized level and reports accepted transitions.
// A new input value must be sampled on STABLE consecutive rising edges before
// it is accepted. Shorter runs are discarded as glitches. Each accepted
// transition produces a one-cycle rise/fall strobe and bumps a wrapping
// event counter.
//
// Parameters:
//   STABLE   consecutive identical samples needed to accept a transition (>= 2)
//   CNT_W    width of edge_cnt
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   rst       in   synchronous active-high reset (highest priority)
//   sig_in    in   synchronized input level
//   cnt_clr   in   synchronous clear of edge_cnt (an edge in the same cycle
//                  still counts, leaving edge_cnt = 1)
//   level     out  debounced level, registered
//   rise      out  one-cycle strobe on an accepted 0->1 transition
//   fall      out  one-cycle strobe on an accepted 1->0 transition
//   edge_cnt  out  accepted-transition count, wraps modulo 2^CNT_W
//   busy      out  high while a transition is being qualified
// ---------------------------------------------------------------------------
module sync_debounce_edge #(
    parameter int STABLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             cnt_clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             busy
);

    localparam int QW = $clog2(STABLE + 1);

    localparam logic [1:0] LOW      = 2'd0;
    localparam logic [1:0] RISE_CHK = 2'd1;
    localparam logic [1:0] HIGH     = 2'd2;
    localparam logic [1:0] FALL_CHK = 2'd3;

    // The entry edge loads q_cnt = 1. The transition is accepted on the edge
    // that sees q_cnt = STABLE-1, which is the STABLE-th matching sample.
    localparam logic [QW-1:0] Q_ZERO = '0;
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE - 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [QW-1:0] q_cnt;
    logic [QW-1:0] q_nxt;
    logic          acc_rise;
    logic          acc_fall;

    // Next-state logic.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt = state;
        q_nxt     = q_cnt;
        acc_rise  = 1'b0;
        acc_fall  = 1'b0;

        case (state)
            LOW: begin
                if (sig_in) begin
                    state_nxt = RISE_CHK;
                    q_nxt     = Q_ONE;
                end
            end

            RISE_CHK: begin
                if (!sig_in) begin
                    // Glitch: drop back without a strobe or a count.
                    state_nxt = LOW;
                    q_nxt     = Q_ZERO;
                end else if (q_cnt == Q_LAST) begin
                    state_nxt = HIGH;
                    q_nxt     = Q_ZERO;
                    acc_rise  = 1'b1;
                end else begin
                    q_nxt = q_cnt + Q_ONE;
                end
            end

            HIGH: begin
                if (!sig_in) begin
                    state_nxt = FALL_CHK;
                    q_nxt     = Q_ONE;
                end
            end

            FALL_CHK: begin
                if (sig_in) begin
                    state_nxt = HIGH;
                    q_nxt     = Q_ZERO;
                end else if (q_cnt == Q_LAST) begin
                    state_nxt = LOW;
                    q_nxt     = Q_ZERO;
                    acc_fall  = 1'b1;
                end else begin
                    q_nxt = q_cnt + Q_ONE;
                end
            end

            default: begin
                state_nxt = LOW;
                q_nxt     = Q_ZERO;
            end
        endcase
    end

    // State, qualification counter and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before this edge regardless of order.
        if (rst) begin
            state    <= LOW;
            q_cnt    <= Q_ZERO;
            level    <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            state <= state_nxt;
            q_cnt <= q_nxt;
            rise  <= acc_rise;
            fall  <= acc_fall;

            if (acc_rise) begin
                level <= 1'b1;
            end else if (acc_fall) begin
                level <= 1'b0;
            end

            // Clear takes effect first, then the same-cycle edge is counted.
            if (cnt_clr) begin
                edge_cnt <= (acc_rise || acc_fall) ? CNT_ONE : '0;
            end else if (acc_rise || acc_fall) begin
                edge_cnt <= edge_cnt + CNT_ONE;
            end
        end
    end

    // Decoded straight from the state register; no path from sig_in.
    assign busy = (state == RISE_CHK) || (state == FALL_CHK);

endmodule
